// File: rtl/mlkem_pkg.sv
// Shared definitions for the ML-KEM ByteDecode stream.
// Holds the modulus, the widest supported coefficient width, the coefficient type,
// the decoder state encoding, and a mask helper for d-bit coefficients.
package mlkem_pkg;

    localparam int unsigned MLKEM_Q     = 3329;
    localparam int unsigned MLKEM_MAX_D = 12;

    localparam int unsigned CoefW = 12;
    localparam int unsigned AccW  = 20;
    localparam int unsigned CntW  = 5;

    typedef logic [CoefW-1:0] coef_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Low d bits set; d is at most 12 so the shift fits in 13 bits.
    function automatic coef_t coef_mask(input logic [3:0] d);
        logic [CoefW:0] m;
        m = (13'd1 << d) - 13'd1;
        return m[CoefW-1:0];
    endfunction

endpackage

// File: rtl/bit_accumulator.sv
// Bit accumulator for the byte-to-coefficient unpacker.
// Bytes are appended LSB-first at the current fill level; a consume drops the low
// "shift" bits. Append and consume may happen together, in which case the new byte
// lands above the bits that remain after the consume.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clear     - empty the accumulator (frame start)
//   append    - add din at bit position count (after any consume this cycle)
//   consume   - shift right by shift and reduce count by shift
//   shift     - coefficient width d
//   din       - byte to append
//   acc       - accumulator contents, bits at and above count are always zero
//   count     - number of valid bits, 0..20
module bit_accumulator
    import mlkem_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            append,
    input  logic            consume,
    input  logic [3:0]      shift,
    input  logic [7:0]      din,
    output logic [AccW-1:0] acc,
    output logic [CntW-1:0] count
);

    logic [AccW-1:0] acc_q, acc_d, base_acc;
    logic [CntW-1:0] cnt_q, cnt_d, base_cnt;

    always_comb begin
        base_acc = acc_q;
        base_cnt = cnt_q;
        if (consume) begin
            base_acc = acc_q >> shift;
            base_cnt = cnt_q - CntW'(shift);
        end
        acc_d = base_acc;
        cnt_d = base_cnt;
        if (append) begin
            // Upper bits are zero by construction, so OR places the byte cleanly.
            acc_d = base_acc | (AccW'(din) << base_cnt);
            cnt_d = base_cnt + CntW'(8);
        end
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc   = acc_q;
    assign count = cnt_q;

endmodule

// File: rtl/byte_decode_stream.sv
// Streaming ML-KEM ByteDecode_d: unpacks 32*d bytes into 256 d-bit coefficients.
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   start_i, d_i          - frame start (IDLE only) and coefficient width 1..MAX_D
//   in_valid_i/in_ready_o - byte input handshake, in_data_i the byte
//   out_valid_o/out_ready_i - coefficient handshake, out_data_o zero-extended,
//                           out_last_o marks coefficient 255
//   busy_o                - not IDLE
//   done_o                - one-cycle pulse at frame end or on a rejected start
//   err_o                 - sticky error (bad d, or d=12 coefficient >= Q)
module byte_decode_stream
    import mlkem_pkg::*;
#(
    parameter int unsigned Q     = MLKEM_Q,
    parameter int unsigned MAX_D = MLKEM_MAX_D
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [3:0]   d_i,
    input  logic         in_valid_i,
    input  logic [7:0]   in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [11:0]  out_data_o,
    output logic         out_last_o,
    input  logic         out_ready_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    state_e          state_q, state_d;
    logic [3:0]      d_q, d_d;
    logic [8:0]      byte_rem_q, byte_rem_d;
    logic [8:0]      coef_rem_q, coef_rem_d;
    logic            err_q, err_d;
    logic            bad_start_q, bad_start_d;

    logic [AccW-1:0] acc;
    logic [CntW-1:0] acc_cnt;
    logic            run, start_ok, clear, accept, consume;
    coef_t           coef;

    assign run      = (state_q == StRun);
    assign start_ok = (d_i != 4'd0) && (32'(d_i) <= MAX_D);
    assign clear    = (state_q == StIdle) && start_i && start_ok;

    // All handshake outputs depend only on registered state.
    assign in_ready_o  = run && (byte_rem_q != 9'd0) && (acc_cnt <= CntW'(12));
    assign out_valid_o = run && (acc_cnt >= CntW'(d_q));
    assign coef        = acc[CoefW-1:0] & coef_mask(d_q);
    assign out_data_o  = coef;
    assign out_last_o  = out_valid_o && (coef_rem_q == 9'd1);

    assign accept  = in_valid_i && in_ready_o;
    assign consume = out_valid_o && out_ready_i;

    assign busy_o = (state_q != StIdle);
    assign done_o = (state_q == StDone) || bad_start_q;
    assign err_o  = err_q;

    bit_accumulator u_acc (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (clear),
        .append  (accept),
        .consume (consume),
        .shift   (d_q),
        .din     (in_data_i),
        .acc     (acc),
        .count   (acc_cnt)
    );

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        byte_rem_d  = byte_rem_q;
        coef_rem_d  = coef_rem_q;
        err_d       = err_q;
        bad_start_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (start_ok) begin
                        state_d    = StRun;
                        d_d        = d_i;
                        byte_rem_d = {d_i, 5'b0};
                        coef_rem_d = 9'd256;
                        err_d      = 1'b0;
                    end else begin
                        err_d       = 1'b1;
                        bad_start_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    byte_rem_d = byte_rem_q - 9'd1;
                end
                if (consume) begin
                    coef_rem_d = coef_rem_q - 9'd1;
                    // Out-of-range d=12 values are flagged but passed through unchanged.
                    if ((d_q == 4'd12) && (32'(coef) >= Q)) begin
                        err_d = 1'b1;
                    end
                    if (coef_rem_q == 9'd1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            d_q         <= '0;
            byte_rem_q  <= '0;
            coef_rem_q  <= '0;
            err_q       <= 1'b0;
            bad_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            byte_rem_q  <= byte_rem_d;
            coef_rem_q  <= coef_rem_d;
            err_q       <= err_d;
            bad_start_q <= bad_start_d;
        end
    end

endmodule

// File: tb/tb_byte_decode_stream.sv
// Directed bench for byte_decode_stream: drives frames with hand-built byte streams
// and compares every consumed coefficient against a precomputed expected table.
module tb_byte_decode_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  d;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0]  bytes [$];
    logic [11:0] exp_c [256];

    always #5 clk = ~clk;

    byte_decode_stream dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .d_i         (d),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_ready_i (out_ready),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, {26'd0, in_ready, out_valid, out_last, done, err, busy}, 32'd0);
        check({tag, "_data"}, {20'd0, out_data}, 32'd0);
    endtask

    // Runs one frame; stop_after > 0 abandons it after that many consumes.
    task automatic run_frame(input logic [3:0] dd, input bit rnd, input int stop_after,
                             output int n_acc, output int n_coef, output int n_done,
                             output logic err_at_done, output logic err_start);
        int   bi;
        int   post;
        bit   held;
        bit   finished;
        logic [12:0] prev;
        n_acc = 0; n_coef = 0; n_done = 0; err_at_done = 1'b0;
        bi = 0; post = -1; held = 1'b0; finished = 1'b0; prev = '0;
        @(negedge clk);
        start = 1'b1;
        d     = dd;
        @(negedge clk);
        start     = 1'b0;
        err_start = err;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
            if (bi < bytes.size() && (!rnd || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_data  = bytes[bi];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (held) begin
                check("stall_hold", {18'd0, out_valid, out_last, out_data}, {18'd0, 1'b1, prev});
            end
            held = 1'b0;
            if (in_valid && in_ready) begin
                bi++;
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (n_coef < 256) begin
                    check($sformatf("coef%0d", n_coef), {20'd0, out_data}, {20'd0, exp_c[n_coef]});
                    check($sformatf("last%0d", n_coef), {31'd0, out_last},
                          {31'd0, (n_coef == 255)});
                end
                n_coef++;
            end else if (out_valid) begin
                held = 1'b1;
                prev = {out_last, out_data};
            end
            if (done) begin
                n_done++;
                err_at_done = err;
                if (post < 0) post = 3;
            end
            @(negedge clk);
            if (stop_after > 0 && n_coef == stop_after) finished = 1'b1;
            if (post > 0) begin
                post--;
                if (post == 0) finished = 1'b1;
            end
        end
        if (!finished) check("frame_timeout", 32'd0, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int   n_acc, n_coef, n_done;
        logic e_done, e_start;

        rst = 1'b1; start = 1'b0; d = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // d=1, 0xAA: bits LSB-first alternate 0,1.
        bytes.delete();
        for (int i = 0; i < 32; i++) bytes.push_back(8'hAA);
        for (int i = 0; i < 256; i++) exp_c[i] = 12'(i & 1);
        run_frame(4'd1, 1'b0, 0, n_acc, n_coef, n_done, e_done, e_start);
        check("d1_coefs", n_coef, 256);
        check("d1_bytes", n_acc, 32);
        check("d1_done", n_done, 1);
        check("d1_err", {31'd0, e_done}, 32'd0);
        check_idle_outputs("d1_after");

        // d=12, f[i]=i packed three bytes per two coefficients.
        bytes.delete();
        for (int k = 0; k < 128; k++) begin
            logic [11:0] f0, f1;
            f0 = 12'(2 * k);
            f1 = 12'(2 * k + 1);
            bytes.push_back(f0[7:0]);
            bytes.push_back({f1[3:0], f0[11:8]});
            bytes.push_back(f1[11:4]);
        end
        for (int i = 0; i < 256; i++) exp_c[i] = 12'(i);
        run_frame(4'd12, 1'b0, 0, n_acc, n_coef, n_done, e_done, e_start);
        check("d12_coefs", n_coef, 256);
        check("d12_bytes", n_acc, 384);
        check("d12_done", n_done, 1);
        check("d12_err", {31'd0, e_done}, 32'd0);

        // d=8 with gaps and random backpressure.
        bytes.delete();
        for (int i = 0; i < 256; i++) bytes.push_back(8'(i));
        for (int i = 0; i < 256; i++) exp_c[i] = 12'(i);
        run_frame(4'd8, 1'b1, 0, n_acc, n_coef, n_done, e_done, e_start);
        check("d8r_coefs", n_coef, 256);
        check("d8r_bytes", n_acc, 256);
        check("d8r_done", n_done, 1);

        // d=12 out-of-range first coefficient.
        bytes.delete();
        bytes.push_back(8'hFF);
        bytes.push_back(8'h0F);
        for (int i = 2; i < 384; i++) bytes.push_back(8'h00);
        exp_c[0] = 12'hFFF;
        for (int i = 1; i < 256; i++) exp_c[i] = 12'h000;
        run_frame(4'd12, 1'b0, 0, n_acc, n_coef, n_done, e_done, e_start);
        check("oor_coefs", n_coef, 256);
        check("oor_done", n_done, 1);
        check("oor_err_at_done", {31'd0, e_done}, 32'd1);
        check("oor_err_held", {31'd0, err}, 32'd1);

        // d=8 frame cut by reset after 100 coefficients; its start clears err.
        bytes.delete();
        for (int i = 0; i < 256; i++) bytes.push_back(8'(i));
        for (int i = 0; i < 256; i++) exp_c[i] = 12'(i);
        run_frame(4'd8, 1'b0, 100, n_acc, n_coef, n_done, e_done, e_start);
        check("err_cleared_by_start", {31'd0, e_start}, 32'd0);
        check("cut_coefs", n_coef, 100);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        rst = 1'b0;
        run_frame(4'd8, 1'b0, 0, n_acc, n_coef, n_done, e_done, e_start);
        check("fresh_coefs", n_coef, 256);
        check("fresh_bytes", n_acc, 256);
        check("fresh_done", n_done, 1);
        check("fresh_err", {31'd0, e_done}, 32'd0);

        // Rejected starts: d=0 then d=13.
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            start = 1'b1;
            d     = (t == 0) ? 4'd0 : 4'd13;
            @(negedge clk);
            start = 1'b0;
            check($sformatf("bad%0d_done", t), {31'd0, done}, 32'd1);
            check($sformatf("bad%0d_err", t), {31'd0, err}, 32'd1);
            check($sformatf("bad%0d_busy", t), {31'd0, busy}, 32'd0);
            check($sformatf("bad%0d_ready", t), {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            check($sformatf("bad%0d_pulse", t), {31'd0, done}, 32'd0);
            check($sformatf("bad%0d_sticky", t), {31'd0, err}, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
